spcore_seq: RTL

Per-core instruction sequencer for spcore. It accepts one decoded 32-bit instruction through a valid/ready handshake. It then drives the core's control inputs (x, y, z, I, aluc, s2, reg_we, en) through source-read, execute and write-back cycles, plus a memory-write phase for STORE. It sits between the warp/instruction broadcast unit and each spcore instance, replacing hand-sequenced control.

---
 rtl/spcore_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/spcore_seq.sv
//------------------------------------------------------------------------------
// spcore_seq
//
// Per-core instruction sequencer. It takes one decoded instruction at a time
// over a valid/ready handshake. It then steps the spcore control inputs through
// source-read, execute and write-back cycles, or through a memory-write phase
// for STORE. All outputs are registered.
//
// Instruction word: {op[31:28], x[27:24], y[23:20], z[19:16], imm[15:0]}
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   instr_valid  an instruction is offered on instr
//   instr        the offered instruction word
//   instr_ready  sequencer is idle and will accept on the next edge
//   core_x/y/z   register selects driven to spcore
//   core_I       immediate driven to spcore
//   core_aluc    ALU function select driven to spcore
//   core_s2      write-back mux select driven to spcore
//   core_reg_we  register-file write enable (high only in write-back)
//   core_en      spcore enable (high while an instruction is in flight)
//   mem_we       store request to data memory
//   mem_ack      data memory accepted the store
//   done         one-cycle pulse when an instruction retires
//   err          one-cycle pulse alongside done for illegal op / store timeout
//   retired      running count of done pulses (wraps)
//------------------------------------------------------------------------------
module spcore_seq #(
    parameter int RETIRE_W    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         instr,
    output logic                instr_ready,
    output logic [3:0]          core_x,
    output logic [3:0]          core_y,
    output logic [3:0]          core_z,
    output logic [15:0]         core_I,
    output logic [3:0]          core_aluc,
    output logic [1:0]          core_s2,
    output logic                core_reg_we,
    output logic                core_en,
    output logic                mem_we,
    input  logic                mem_ack,
    output logic                done,
    output logic                err,
    output logic [RETIRE_W-1:0] retired
);

    // ALU function codes understood by spcore
    localparam logic [3:0] ALUC_ADD     = 4'd0;
    localparam logic [3:0] ALUC_MUL     = 4'd1;
    localparam logic [3:0] ALUC_MAD     = 4'd2;
    localparam logic [3:0] ALUC_INC     = 4'd3;
    localparam logic [3:0] ALUC_CLEAR   = 4'd4;
    localparam logic [3:0] ALUC_CORE_ID = 4'd5;
    localparam logic [3:0] ALUC_N_CORES = 4'd6;

    // spcore write-back source select
    localparam logic [1:0] MUXD_FROM_ALU = 2'd0;
    localparam logic [1:0] MUXD_FROM_I   = 2'd1;

    // Opcodes
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_LOADI    = 4'd1;
    localparam logic [3:0] OP_ADD      = 4'd2;
    localparam logic [3:0] OP_MUL      = 4'd3;
    localparam logic [3:0] OP_MAD      = 4'd4;
    localparam logic [3:0] OP_INC      = 4'd5;
    localparam logic [3:0] OP_CLEAR    = 4'd6;
    localparam logic [3:0] OP_LOADC_ID = 4'd7;
    localparam logic [3:0] OP_LOADC_N  = 4'd8;
    localparam logic [3:0] OP_STORE    = 4'd9;

    localparam logic [7:0]          TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic [RETIRE_W-1:0] RETIRE_ONE  = RETIRE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WB,
        MEM
    } state_t;

    state_t     state;
    logic [3:0] op_q;
    logic [7:0] wait_cnt;

    // Opcodes 2..8 go through the ALU and need an execute cycle
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LOADC_N);
    endfunction

    // Translate an ALU opcode into the spcore function select
    function automatic logic [3:0] alu_code(input logic [3:0] op);
        logic [3:0] code;
        code = ALUC_CLEAR;
        case (op)
            OP_ADD:      code = ALUC_ADD;
            OP_MUL:      code = ALUC_MUL;
            OP_MAD:      code = ALUC_MAD;
            OP_INC:      code = ALUC_INC;
            OP_CLEAR:    code = ALUC_CLEAR;
            OP_LOADC_ID: code = ALUC_CORE_ID;
            OP_LOADC_N:  code = ALUC_N_CORES;
            default:     code = ALUC_CLEAR;
        endcase
        return code;
    endfunction

    // Sequencer FSM. Every output is a register updated here, so the core
    // sees clean control for whole cycles. done/err default low each cycle
    // and are raised only on the edge that enters the retiring cycle; the
    // retire counter moves on that same edge so it lines up with done.
    // Fields x/y/z/I are captured only at accept and therefore hold for the
    // whole instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= OP_NOP;
            wait_cnt    <= 8'd0;
            instr_ready <= 1'b1;
            core_x      <= 4'd0;
            core_y      <= 4'd0;
            core_z      <= 4'd0;
            core_I      <= 16'd0;
            core_aluc   <= ALUC_CLEAR;
            core_s2     <= MUXD_FROM_ALU;
            core_reg_we <= 1'b0;
            core_en     <= 1'b0;
            mem_we      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            retired     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        op_q        <= instr[31:28];
                        core_x      <= instr[27:24];
                        core_y      <= instr[23:20];
                        core_z      <= instr[19:16];
                        core_I      <= instr[15:0];
                        core_en     <= 1'b1;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end

                READ: begin
                    if (op_q == OP_LOADI) begin
                        // Immediate load skips the ALU entirely
                        core_aluc   <= ALUC_CLEAR;
                        core_s2     <= MUXD_FROM_I;
                        core_reg_we <= 1'b1;
                        done        <= 1'b1;
                        retired     <= retired + RETIRE_ONE;
                        state       <= WB;
                    end else if (is_alu_op(op_q)) begin
                        core_aluc <= alu_code(op_q);
                        core_s2   <= MUXD_FROM_ALU;
                        state     <= EXEC;
                    end else if (op_q == OP_STORE) begin
                        mem_we   <= 1'b1;
                        wait_cnt <= 8'd0;
                        state    <= MEM;
                    end else begin
                        // NOP retires cleanly, anything else is illegal
                        core_en     <= 1'b0;
                        instr_ready <= 1'b1;
                        done        <= 1'b1;
                        err         <= (op_q != OP_NOP);
                        retired     <= retired + RETIRE_ONE;
                        state       <= IDLE;
                    end
                end

                EXEC: begin
                    // aluc/s2 stay as set in READ through write-back
                    core_reg_we <= 1'b1;
                    done        <= 1'b1;
                    retired     <= retired + RETIRE_ONE;
                    state       <= WB;
                end

                WB: begin
                    core_reg_we <= 1'b0;
                    core_en     <= 1'b0;
                    core_aluc   <= ALUC_CLEAR;
                    core_s2     <= MUXD_FROM_ALU;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end

                MEM: begin
                    // An ack on the last allowed cycle still counts as success
                    if (mem_ack || (wait_cnt + 8'd1 == TIMEOUT_CNT)) begin
                        mem_we      <= 1'b0;
                        core_en     <= 1'b0;
                        instr_ready <= 1'b1;
                        done        <= 1'b1;
                        err         <= !mem_ack;
                        retired     <= retired + RETIRE_ONE;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    core_reg_we <= 1'b0;
                    core_en     <= 1'b0;
                    mem_we      <= 1'b0;
                    core_aluc   <= ALUC_CLEAR;
                    core_s2     <= MUXD_FROM_ALU;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
